simmem_wresp_release_scheduler: RTL

SIMMEM_WRESP_RELEASE_SCHEDULER -- requirements
Module: simmem_wresp_release_scheduler

---
 rtl/simmem_pkg.sv | 15 +
 rtl/simmem_age_matrix.sv | 59 +++++
 rtl/simmem_wresp_release_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/simmem_pkg.sv
// Shared sizing for the simulated-memory write-response path and the
// release scheduler's state encoding.
package simmem_pkg;

  localparam int unsigned WriteRespBankTotalCapacity = 8;
  localparam int unsigned WriteRespBankAddrWidth     = 3;
  localparam int unsigned IDWidth                    = 4;

  // Release scheduler handshake state: IDLE has nothing offered, GRANT holds a slot.
  typedef enum logic {
    REL_IDLE  = 1'b0,
    REL_GRANT = 1'b1
  } rel_state_e;

endpackage

// File: rtl/simmem_age_matrix.sv
// Relative-age tracker for the write-response slots. older[j][k] = 1 means
// slot j was reserved before slot k. Also picks the oldest requesting slot.
module simmem_age_matrix
  import simmem_pkg::*;
#(
  parameter int unsigned NumEntries = WriteRespBankTotalCapacity,
  parameter int unsigned AddrWidth  = WriteRespBankAddrWidth
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   set_valid,
  input  logic [AddrWidth-1:0]                   set_idx,
  input  logic [NumEntries-1:0]                  clr_onehot,
  input  logic [NumEntries-1:0]                  live,
  input  logic [NumEntries-1:0]                  req,
  output logic [NumEntries-1:0][NumEntries-1:0]  older,
  output logic [NumEntries-1:0]                  oldest
);

  logic [NumEntries-1:0][NumEntries-1:0] older_reg;
  logic [NumEntries-1:0][NumEntries-1:0] older_next;

  // A newly reserved slot becomes the youngest: its row clears and its column
  // records every slot still live after this cycle's release.
  always_comb begin
    older_next = older_reg;
    if (set_valid) begin
      for (int j = 0; j < NumEntries; j++) begin
        older_next[set_idx][j] = 1'b0;
      end
      for (int j = 0; j < NumEntries; j++) begin
        if (AddrWidth'(j) != set_idx) begin
          older_next[j][set_idx] = live[j] & ~clr_onehot[j];
        end
      end
    end
  end

  // Age matrix storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      older_reg <= '0;
    end else begin
      older_reg <= older_next;
    end
  end

  assign older = older_reg;

  // A requester wins when no other requester is older than it.
  for (genvar gi = 0; gi < NumEntries; gi++) begin : g_oldest
    logic [NumEntries-1:0] col;
    for (genvar gj = 0; gj < NumEntries; gj++) begin : g_col
      assign col[gj] = older_reg[gj][gi];
    end
    assign oldest[gi] = req[gi] & ~|(req & col);
  end

endmodule

// File: rtl/simmem_wresp_release_scheduler.sv
// Picks which write-response slot to release next: a slot is releasable once
// its delay expired and no older slot with the same AXI ID is still pending.
// The oldest releasable slot is offered and held stable until accepted.
module simmem_wresp_release_scheduler
  import simmem_pkg::*;
#(
  parameter int unsigned NumEntries = WriteRespBankTotalCapacity,
  parameter int unsigned AddrWidth  = WriteRespBankAddrWidth,
  parameter int unsigned IdWidth    = IDWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rsv_valid_i,
  input  logic [AddrWidth-1:0]  rsv_addr_i,
  input  logic [IdWidth-1:0]    rsv_id_i,
  input  logic [NumEntries-1:0] release_en_i,
  input  logic                  out_ready_i,
  output logic                  out_valid_o,
  output logic [AddrWidth-1:0]  out_addr_o,
  output logic [NumEntries-1:0] released_onehot_o,
  output logic [NumEntries-1:0] pending_o,
  output logic [15:0]           stall_cnt_o
);

  rel_state_e                            state;
  rel_state_e                            state_next;
  logic [AddrWidth-1:0]                  addr;
  logic [AddrWidth-1:0]                  addr_next;
  logic [AddrWidth-1:0]                  oldest_idx;
  logic [NumEntries-1:0]                 pending;
  logic [NumEntries-1:0]                 pending_next;
  logic [NumEntries-1:0]                 pend_eff;
  logic [NumEntries-1:0]                 rsv_onehot;
  logic [NumEntries-1:0]                 hs_onehot;
  logic [NumEntries-1:0]                 eligible;
  logic [NumEntries-1:0]                 oldest;
  logic [NumEntries-1:0][NumEntries-1:0] older;
  logic [IdWidth-1:0]                    id_mem [NumEntries];
  logic [15:0]                           stall_cnt;
  logic                                  handshake;
  logic                                  any_eligible;

  assign handshake = out_valid_o & out_ready_i;

  // Per-slot decode of the reservation and of the release handshake.
  for (genvar gi = 0; gi < NumEntries; gi++) begin : g_decode
    assign rsv_onehot[gi] = rsv_valid_i & (rsv_addr_i == AddrWidth'(gi));
    assign hs_onehot[gi]  = handshake & (addr == AddrWidth'(gi));
  end

  // Slots still pending once this cycle's release is taken out; a reservation
  // of the same slot re-sets it, so the reservation wins.
  assign pend_eff     = pending & ~hs_onehot;
  assign pending_next = pend_eff | rsv_onehot;

  // Pending-slot vector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Per-slot AXI ID captured at reservation time.
  for (genvar gi = 0; gi < NumEntries; gi++) begin : g_id
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        id_mem[gi] <= '0;
      end else if (rsv_onehot[gi]) begin
        id_mem[gi] <= rsv_id_i;
      end
    end
  end

  // Same-ID ordering: a slot is blocked while an older slot with its ID is pending.
  for (genvar gi = 0; gi < NumEntries; gi++) begin : g_elig
    logic [NumEntries-1:0] blockers;
    for (genvar gj = 0; gj < NumEntries; gj++) begin : g_blk
      assign blockers[gj] = pend_eff[gj] & older[gj][gi] & (id_mem[gj] == id_mem[gi]);
    end
    assign eligible[gi] = pend_eff[gi] & release_en_i[gi] & ~|blockers;
  end

  simmem_age_matrix #(
    .NumEntries (NumEntries),
    .AddrWidth  (AddrWidth)
  ) u_age (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set_valid  (rsv_valid_i),
    .set_idx    (rsv_addr_i),
    .clr_onehot (hs_onehot),
    .live       (pending),
    .req        (eligible),
    .older      (older),
    .oldest     (oldest)
  );

  assign any_eligible = |eligible;

  // Encode the oldest eligible slot (at most one bit set).
  always_comb begin
    oldest_idx = '0;
    for (int k = 0; k < NumEntries; k++) begin
      if (oldest[k]) begin
        oldest_idx = AddrWidth'(k);
      end
    end
  end

  // State register together with the held grant address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= REL_IDLE;
      addr  <= '0;
    end else begin
      state <= state_next;
      addr  <= addr_next;
    end
  end

  // Next state: the grant address only moves when entering GRANT or on a handshake.
  always_comb begin
    state_next = state;
    addr_next  = addr;
    case (state)
      REL_IDLE: begin
        if (any_eligible) begin
          state_next = REL_GRANT;
          addr_next  = oldest_idx;
        end
      end
      REL_GRANT: begin
        if (handshake) begin
          if (any_eligible) begin
            addr_next = oldest_idx;
          end else begin
            state_next = REL_IDLE;
          end
        end
      end
      default: state_next = REL_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    out_valid_o = (state == REL_GRANT);
    out_addr_o  = addr;
  end

  // Saturating count of cycles where a grant waits on the consumer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (out_valid_o && !out_ready_i && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign released_onehot_o = hs_onehot;
  assign pending_o         = pending;
  assign stall_cnt_o       = stall_cnt;

  // Re-reserving a slot that stays pending this cycle corrupts its age and ID.
  reservation_on_pending: assert property (
    @(posedge clk_i) disable iff (!rst_ni) rsv_valid_i |-> !pend_eff[rsv_addr_i]
  );

endmodule
